// File: rtl/fde_cpu_pkg.sv
// Shared definitions for the fetch/decode/execute accumulator CPU:
// opcode values and FSM state encoding.
package fde_cpu_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_STA = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JZ  = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALT
  } state_e;

endpackage

// File: rtl/fde_cpu_mem.sv
// Unified program/data memory: one synchronous write port and three
// asynchronous read ports (instruction fetch, operand, debug).
// Contents are deliberately not reset.
module fde_cpu_mem #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_rdata,
  input  logic [AW-1:0] opnd_addr,
  output logic [DW-1:0] opnd_rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata
);

  logic [DW-1:0] mem_q [2**AW];

  // Single write port; program load and STA share it.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign fetch_rdata = mem_q[fetch_addr];
  assign opnd_rdata  = mem_q[opnd_addr];
  assign dbg_rdata   = mem_q[dbg_addr];

endmodule

// File: rtl/fde_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH -> DECODE -> EXECUTE per instruction,
// with start/halt control, a program-load port and a debug read port.
module fde_cpu_core
  import fde_cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_wdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata,
  output logic [DW-1:0] acc_o,
  output logic [AW-1:0] pc_o,
  output logic          carry_o,
  output logic          zero_o,
  output logic          busy_o,
  output logic          halted_o,
  output logic [CW-1:0] retired_o
);

  if (DW < AW + 3) begin : g_width_check
    $error("fde_cpu_core: DW must be at least AW+3");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic [CW-1:0] retired_q, retired_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] fetch_rdata;
  logic [DW-1:0] opnd_rdata;

  logic [2:0]    op;
  logic [AW-1:0] op_addr;
  logic [DW:0]   alu_sum;
  logic [DW:0]   alu_diff;
  logic          ir_unused;

  assign op        = ir_q[DW-1 -: 3];
  assign op_addr   = ir_q[AW-1:0];
  // Middle instruction bits carry no meaning.
  assign ir_unused = ^ir_q;

  fde_cpu_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk         (clk),
    .we          (mem_we),
    .waddr       (mem_waddr),
    .wdata       (mem_wdata),
    .fetch_addr  (pc_q),
    .fetch_rdata (fetch_rdata),
    .opnd_addr   (op_addr),
    .opnd_rdata  (opnd_rdata),
    .dbg_addr    (dbg_addr),
    .dbg_rdata   (dbg_rdata)
  );

  // Next-state, datapath and memory-write control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    retired_d = retired_q;
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_wdata;
    // Extra top bit holds the carry out (ADD) or the borrow (SUB).
    alu_sum   = {1'b0, acc_q} + {1'b0, mdr_q};
    alu_diff  = {1'b0, acc_q} - {1'b0, mdr_q};

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        mem_we = prog_we;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = fetch_rdata;
        pc_d    = pc_q + AW'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        mdr_d   = opnd_rdata;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        retired_d = retired_q + CW'(1);
        state_d   = ST_FETCH;
        unique case (op)
          OP_LDA: begin
            acc_d  = mdr_q;
            zero_d = (mdr_q == '0);
          end
          OP_ADD: begin
            acc_d   = alu_sum[DW-1:0];
            carry_d = alu_sum[DW];
            zero_d  = (alu_sum[DW-1:0] == '0);
          end
          OP_SUB: begin
            acc_d   = alu_diff[DW-1:0];
            carry_d = alu_diff[DW];
            zero_d  = (alu_diff[DW-1:0] == '0);
          end
          OP_STA: begin
            mem_we    = 1'b1;
            mem_waddr = op_addr;
            mem_wdata = acc_q;
          end
          OP_JMP: pc_d = op_addr;
          OP_JZ:  if (zero_q) pc_d = op_addr;
          OP_HLT: state_d = ST_HALT;
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      acc_q     <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      retired_q <= retired_d;
    end
  end

  assign acc_o     = acc_q;
  assign pc_o      = pc_q;
  assign carry_o   = carry_q;
  assign zero_o    = zero_q;
  assign retired_o = retired_q;
  assign busy_o    = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXECUTE);
  assign halted_o  = (state_q == ST_HALT);

endmodule

// File: tb/tb_fde_cpu_core.sv
// Directed bench for fde_cpu_core: table of whole-program vectors plus
// hand-written sequences for wrap, reset-mid-run and port corner cases.
module tb_fde_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_wdata = '0;
  logic [3:0]  dbg_addr = '0;
  logic [7:0]  dbg_rdata;
  logic [7:0]  acc_o;
  logic [3:0]  pc_o;
  logic        carry_o, zero_o, busy_o, halted_o;
  logic [15:0] retired_o;

  int n_chk = 0;
  int n_fail = 0;

  fde_cpu_core #(.DW(8), .AW(4), .CW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .acc_o      (acc_o),
    .pc_o       (pc_o),
    .carry_o    (carry_o),
    .zero_o     (zero_o),
    .busy_o     (busy_o),
    .halted_o   (halted_o),
    .retired_o  (retired_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0][7:0] img;
    int               cycles;
    logic [7:0]       acc;
    logic             carry;
    logic             zero;
    logic [3:0]       pc;
    logic [15:0]      ret;
    logic [3:0]       chk_a;
    logic [7:0]       chk_v;
  } vec_t;

  localparam int NV = 7;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input logic [15:0][7:0] img);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      prog_we    = 1'b1;
      prog_addr  = 4'(a);
      prog_wdata = img[a];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt(cyc);
  endtask

  function automatic logic [7:0] peek(input logic [3:0] a);
    return dut.u_mem.mem_q[a];
  endfunction

  initial begin
    int cyc;
    logic [15:0][7:0] zeros;
    logic [15:0][7:0] img;
    zeros = '0;

    for (int i = 0; i < NV; i++) vec[i].img = '0;
    // add/store
    vec[0].img[0] = 8'h28; vec[0].img[1] = 8'h49; vec[0].img[2] = 8'h8A;
    vec[0].img[3] = 8'hE0; vec[0].img[8] = 8'h05; vec[0].img[9] = 8'h0A;
    vec[0].cycles = 12; vec[0].acc = 8'h0F; vec[0].carry = 0; vec[0].zero = 0;
    vec[0].pc = 4; vec[0].ret = 4; vec[0].chk_a = 10; vec[0].chk_v = 8'h0F;
    // add overflow
    vec[1] = vec[0];
    vec[1].img[8] = 8'hF0; vec[1].img[9] = 8'h20;
    vec[1].acc = 8'h10; vec[1].carry = 1; vec[1].chk_v = 8'h10;
    // sub borrow
    vec[2].img[0] = 8'h28; vec[2].img[1] = 8'h69; vec[2].img[2] = 8'hE0;
    vec[2].img[8] = 8'h05; vec[2].img[9] = 8'h0A;
    vec[2].cycles = 9; vec[2].acc = 8'hFB; vec[2].carry = 1; vec[2].zero = 0;
    vec[2].pc = 3; vec[2].ret = 3; vec[2].chk_a = 9; vec[2].chk_v = 8'h0A;
    // sub to zero
    vec[3] = vec[2];
    vec[3].img[9] = 8'h05;
    vec[3].acc = 8'h00; vec[3].carry = 0; vec[3].zero = 1; vec[3].chk_v = 8'h05;
    // JZ taken
    vec[4].img[0] = 8'h28; vec[4].img[1] = 8'hC3; vec[4].img[2] = 8'hE0;
    vec[4].img[3] = 8'hE0; vec[4].img[8] = 8'h00;
    vec[4].cycles = 9; vec[4].acc = 8'h00; vec[4].carry = 0; vec[4].zero = 1;
    vec[4].pc = 4; vec[4].ret = 3; vec[4].chk_a = 8; vec[4].chk_v = 8'h00;
    // self-modifying: STA plants HLT at the next fetch address
    vec[5].img[0] = 8'h28; vec[5].img[1] = 8'h82; vec[5].img[2] = 8'h00;
    vec[5].img[3] = 8'hE0; vec[5].img[8] = 8'hE0;
    vec[5].cycles = 9; vec[5].acc = 8'hE0; vec[5].carry = 0; vec[5].zero = 0;
    vec[5].pc = 3; vec[5].ret = 3; vec[5].chk_a = 2; vec[5].chk_v = 8'hE0;
    // JZ falls through (last, so the resume-from-HALT sequence follows it)
    vec[6] = vec[4];
    vec[6].img[8] = 8'h01;
    vec[6].acc = 8'h01; vec[6].zero = 0; vec[6].pc = 3; vec[6].chk_v = 8'h01;

    // Reset state
    #1;
    chk("rst_acc", 32'(acc_o), 0);
    chk("rst_pc", 32'(pc_o), 0);
    chk("rst_flags", {carry_o, zero_o}, 0);
    chk("rst_busy_halt", {busy_o, halted_o}, 0);
    chk("rst_retired", 32'(retired_o), 0);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      load(vec[i].img);
      run(cyc);
      chk($sformatf("v%0d_cycles", i), cyc, vec[i].cycles);
      chk($sformatf("v%0d_acc", i), 32'(acc_o), 32'(vec[i].acc));
      chk($sformatf("v%0d_carry", i), 32'(carry_o), 32'(vec[i].carry));
      chk($sformatf("v%0d_zero", i), 32'(zero_o), 32'(vec[i].zero));
      chk($sformatf("v%0d_pc", i), 32'(pc_o), 32'(vec[i].pc));
      chk($sformatf("v%0d_retired", i), 32'(retired_o), 32'(vec[i].ret));
      dbg_addr = vec[i].chk_a;
      #1;
      chk($sformatf("v%0d_mem", i), 32'(dbg_rdata), 32'(vec[i].chk_v));
    end

    // Resume from HALT: executes the HLT at address 3
    run(cyc);
    chk("resume_cycles", cyc, 3);
    chk("resume_pc", 32'(pc_o), 4);
    chk("resume_retired", 32'(retired_o), 4);

    // Simultaneous write + start in IDLE: the new word at pc is fetched
    do_reset();
    img = '0;
    img[0] = 8'hE0; img[1] = 8'hE0; img[8] = 8'h07;
    load(img);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 8'h28; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_halt(cyc);
    chk("wrstart_cycles", cyc, 6);
    chk("wrstart_acc", 32'(acc_o), 8'h07);
    chk("wrstart_pc", 32'(pc_o), 2);
    dbg_addr = 4'd0;
    #1;
    chk("wrstart_mem", 32'(dbg_rdata), 8'h28);

    // PC wrap over all-NOP memory; writes and start during the run are ignored
    do_reset();
    load(zeros);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      prog_we    = (c == 10);
      prog_addr  = 4'd5;
      prog_wdata = 8'hFF;
      start      = (c == 20);
    end
    chk("wrap_pc", 32'(pc_o), 0);
    chk("wrap_retired", 32'(retired_o), 16);
    chk("wrap_halted", 32'(halted_o), 0);
    chk("wrap_busy", 32'(busy_o), 1);
    prog_we = 1'b0; start = 1'b0;
    dbg_addr = 4'd5;
    #1;
    chk("wrap_ignored_write", 32'(dbg_rdata), 0);

    // Reset during DECODE of STA
    do_reset();
    load(vec[0].img);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_acc_before", 32'(acc_o), 8'h0F);
    rst = 1'b0;
    #1;
    chk("mid_acc", 32'(acc_o), 0);
    chk("mid_pc", 32'(pc_o), 0);
    chk("mid_retired", 32'(retired_o), 0);
    chk("mid_state", {busy_o, halted_o, carry_o, zero_o}, 0);
    dbg_addr = 4'd10;
    #1;
    chk("mid_mem_untouched", 32'(dbg_rdata), 0);
    chk("mid_prog_kept", 32'(peek(4'd2)), 8'h8A);
    @(negedge clk);
    rst = 1'b1;
    run(cyc);
    chk("rerun_cycles", cyc, 12);
    chk("rerun_acc", 32'(acc_o), 8'h0F);
    #1;
    chk("rerun_mem", 32'(dbg_rdata), 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fde_cpu_core.md
Name: fde_cpu_core

Overview:
- Parametrised multi-cycle fetch/decode/execute accumulator CPU; successor to the 2-bit NOP/ADD core.
- Adds configurable data and address widths, an 8-opcode ISA, a load/store/branch datapath and carry/zero flags.
- Adds an explicit FSM with start/halt, a program-load port and a debug memory read port.
- Sits standalone under a testbench or a board top; the program is loaded via the write port, then `start` is pulsed.

Parameters:
- DW, 8: data/instruction word width; must satisfy DW >= AW+3 (elaboration-time check).
- AW, 4: address width; unified memory depth is 2**AW words.
- CW, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  leaves IDLE/HALT and begins fetching at the current pc.
- prog_we  in  1  memory write strobe; honoured only in IDLE or HALT.
- prog_addr  in  AW  program-load address.
- prog_wdata  in  DW  program-load data.
- dbg_addr  in  AW  debug read address.
- dbg_rdata  out  DW  combinational mem[dbg_addr].
- acc_o  out  DW  accumulator.
- pc_o  out  AW  program counter.
- carry_o  out  1  carry/borrow flag.
- zero_o  out  1  zero flag.
- busy_o  out  1  high in FETCH, DECODE and EXECUTE.
- halted_o  out  1  high in HALT.
- retired_o  out  CW  count of completed instructions; wraps modulo 2**CW.

Behaviour:
- Reset (rst low, async):
  - state=IDLE; pc, acc, ir, mdr, carry, zero and retired all 0.
  - Memory contents are NOT reset.
  - Reset mid-instruction abandons that instruction; no memory write occurs unless EXECUTE of STA had already been clocked.
- Instruction format: opcode = ir[DW-1:DW-3]; operand address = ir[AW-1:0]; remaining bits are ignored.
- Opcodes: NOP=0, LDA=1, ADD=2, SUB=3, STA=4, JMP=5, JZ=6, HLT=7.
- FSM (one state per cycle):
  - IDLE: start -> FETCH.
  - FETCH: ir <= mem[pc]; pc <= pc+1 (wraps from 2**AW-1 to 0); -> DECODE.
  - DECODE: mdr <= mem[ir addr]; -> EXECUTE.
  - EXECUTE: performs the op; retired <= retired+1; -> HALT if HLT, else -> FETCH.
  - HALT: start -> FETCH, continuing at pc (the address following the HLT).
- Every instruction takes exactly 3 cycles from entering FETCH to the next FETCH.
- Execute semantics:
  - NOP: no state change.
  - LDA: acc <= mdr; zero updated; carry unchanged.
  - ADD: {carry,acc} <= acc + mdr, computed DW+1 bits wide; zero updated.
  - SUB: acc <= acc - mdr; carry <= 1 iff acc < mdr (borrow), unsigned; zero updated.
  - STA: mem[addr] <= acc; flags unchanged.
  - JMP: pc <= addr.
  - JZ: pc <= addr if zero==1, else pc unchanged.
  - HLT: no datapath change.
- Write-port and start rules:
  - prog_we while busy_o is ignored (no write).
  - start while busy_o is ignored.
  - prog_we and start in the same IDLE cycle: the write commits and FETCH begins next cycle; if prog_addr==pc, the new word is fetched.
- Self-modifying code: STA to the next fetch address is visible to the following FETCH.
- dbg_rdata is purely combinational from the memory array; it reflects STA results the cycle after EXECUTE.

Decomposition:
- Package fde_cpu_pkg holds the opcode localparams and the state encoding (IDLE, FETCH, DECODE, EXECUTE, HALT).
- One sub-module, fde_cpu_mem: 2**AW x DW array with one sync write port and three async read ports (fetch, operand, debug).
- FSM, registers and ALU stay in fde_cpu_core.

Test Plan:
- Add/store: load mem[0..3]=28,49,8A,E0 and mem[8]=05, mem[9]=0A (hex); pulse start.
  - Expect halted_o after 12 cycles with acc=0F, mem[10]=0F, carry=0, zero=0, retired=4, pc=4.
- ADD overflow: mem[8]=F0, mem[9]=20, same program -> acc=10, carry=1, zero=0.
- SUB borrow: program 28,69,E0 with mem[8]=05, mem[9]=0A -> acc=FB, carry=1. Then mem[9]=05 -> acc=00, zero=1, carry=0.
- Branch: program 28,C3,E0,E0 with mem[8]=00.
  - JZ is taken: halts at the HLT at address 3, pc=4, retired=3.
  - With mem[8]=01 the JZ falls through: halts at address 2, pc=3.
- PC wrap and ignored writes: memory all 00 (NOP); start.
  - After 48 cycles: pc=0, retired=16, halted_o=0.
  - A prog_we issued during the run leaves the target word unchanged.
- Reset mid-run: assert rst during DECODE of STA.
  - Outputs zero immediately (async); target word unchanged; state=IDLE.
  - Memory retains the program; a fresh start reruns it with identical results.
